reservation_station: RTL and testbench

- Parameterised Tomasulo reservation station between decode/issue and one ALU functional unit.
- Accepts decoded ops with operand values or producer tags.
- Snoops the common data bus (CDB) to capture pending operands.
- Dispatches ready ops to its ALU; the entry tag is carried through so the ALU result can be broadcast on the CDB.

---
 rtl/reservation_station.sv | 211 +++++++++++++++++++++
 tb/tb_reservation_station.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds decoded ops until both operands are known, snoops the CDB, feeds one ALU.
// Latency: issue with ready operands -> dispatch eligible next cycle; CDB capture at edge N -> eligible in cycle N+1.
// Backpressure: issue_ready_out low when all rows busy; dispatch holds its selected entry while dispatch_ready_in is low.
//
// Ports:
//   clk_in, rst_in                        clock, synchronous active-high reset
//   issue_*                               valid/ready issue of {op, vj/qj, vk/qk}; issue_tag_out names the row to be filled
//   dispatch_*                            valid/ready dispatch of {op, vj, vk, tag} to the ALU
//   cdb_valid_in/cdb_tag_in/cdb_data_in   common data bus broadcast (tag 0 never matches)
//   count_out                             registered number of busy rows
//
// Optional build macro RS_AGE_ORDER_EN: oldest-ready-first dispatch using per-row age ranks.
// Without it, dispatch picks the lowest-index ready row and no age state exists.
module reservation_station #(
  parameter int ENTRIES = 3,
  parameter int RS_ID   = 1,
  parameter int DATA_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              issue_valid_in,
  output logic              issue_ready_out,
  input  logic [3:0]        issue_op_in,
  input  logic [DATA_W-1:0] issue_vj_in,
  input  logic [3:0]        issue_qj_in,
  input  logic [DATA_W-1:0] issue_vk_in,
  input  logic [3:0]        issue_qk_in,
  output logic [3:0]        issue_tag_out,
  output logic              dispatch_valid_out,
  input  logic              dispatch_ready_in,
  output logic [3:0]        dispatch_op_out,
  output logic [DATA_W-1:0] dispatch_vj_out,
  output logic [DATA_W-1:0] dispatch_vk_out,
  output logic [3:0]        dispatch_tag_out,
  input  logic              cdb_valid_in,
  input  logic [3:0]        cdb_tag_in,
  input  logic [DATA_W-1:0] cdb_data_in,
  output logic [2:0]        count_out
);

  localparam logic [1:0] STATION_ID = 2'(RS_ID);

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [3:0]         op_q [ENTRIES];
  logic [3:0]         op_d [ENTRIES];
  logic [DATA_W-1:0]  vj_q [ENTRIES];
  logic [DATA_W-1:0]  vj_d [ENTRIES];
  logic [3:0]         qj_q [ENTRIES];
  logic [3:0]         qj_d [ENTRIES];
  logic [DATA_W-1:0]  vk_q [ENTRIES];
  logic [DATA_W-1:0]  vk_d [ENTRIES];
  logic [3:0]         qk_q [ENTRIES];
  logic [3:0]         qk_d [ENTRIES];
  logic [2:0]         count_q, count_d;
`ifdef RS_AGE_ORDER_EN
  // Rank 0 is the oldest busy row; ranks of busy rows are always 0..count-1.
  logic [1:0]         age_q [ENTRIES];
  logic [1:0]         age_d [ENTRIES];
  logic [1:0]         sel_age;
`endif

  logic               free_vld, sel_vld, issue_fire, disp_fire, cdb_hit;
  logic [1:0]         free_idx, sel_idx;
  logic [ENTRIES-1:0] rdy;

  // Free-row search and ready-row selection, all on registered state.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    rdy      = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = 2'(i);
      end
      rdy[i] = busy_q[i] && (qj_q[i] == 4'd0) && (qk_q[i] == 4'd0);
    end
`ifdef RS_AGE_ORDER_EN
    sel_age = '1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (rdy[i] && (!sel_vld || (age_q[i] < sel_age))) begin
        sel_vld = 1'b1;
        sel_idx = 2'(i);
        sel_age = age_q[i];
      end
    end
`else
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_vld = 1'b1;
        sel_idx = 2'(i);
      end
    end
`endif
  end

  assign issue_ready_out    = free_vld;
  assign issue_tag_out      = {STATION_ID, free_idx};
  // Rows present during a reset cycle are being discarded, so nothing may leave.
  assign dispatch_valid_out = sel_vld && !rst_in;
  assign dispatch_tag_out   = {STATION_ID, sel_idx};
  assign issue_fire         = issue_valid_in && free_vld;
  assign disp_fire          = dispatch_valid_out && dispatch_ready_in;
  assign cdb_hit            = cdb_valid_in && (cdb_tag_in != 4'd0);
  assign count_out          = count_q;

  always_comb begin
    dispatch_op_out = '0;
    dispatch_vj_out = '0;
    dispatch_vk_out = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel_idx == 2'(i)) begin
        dispatch_op_out = op_q[i];
        dispatch_vj_out = vj_q[i];
        dispatch_vk_out = vk_q[i];
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    op_d    = op_q;
    vj_d    = vj_q;
    qj_d    = qj_q;
    vk_d    = vk_q;
    qk_d    = qk_q;
    count_d = count_q;
`ifdef RS_AGE_ORDER_EN
    age_d   = age_q;
`endif
    for (int i = 0; i < ENTRIES; i++) begin
      // CDB snoop on waiting operands.
      if (cdb_hit && busy_q[i] && (qj_q[i] == cdb_tag_in)) begin
        vj_d[i] = cdb_data_in;
        qj_d[i] = 4'd0;
      end
      if (cdb_hit && busy_q[i] && (qk_q[i] == cdb_tag_in)) begin
        vk_d[i] = cdb_data_in;
        qk_d[i] = 4'd0;
      end
      if (disp_fire && (sel_idx == 2'(i))) begin
        busy_d[i] = 1'b0;
      end
`ifdef RS_AGE_ORDER_EN
      if (disp_fire && busy_q[i] && (age_q[i] > sel_age)) begin
        age_d[i] = age_q[i] - 2'd1;
      end
`endif
      // The issued row was free on registered state, so it never collides with the dispatched row.
      if (issue_fire && (free_idx == 2'(i))) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op_in;
        // Same-cycle bypass: a producer broadcasting now would otherwise be missed forever.
        if (cdb_hit && (issue_qj_in == cdb_tag_in)) begin
          vj_d[i] = cdb_data_in;
          qj_d[i] = 4'd0;
        end else begin
          vj_d[i] = issue_vj_in;
          qj_d[i] = issue_qj_in;
        end
        if (cdb_hit && (issue_qk_in == cdb_tag_in)) begin
          vk_d[i] = cdb_data_in;
          qk_d[i] = 4'd0;
        end else begin
          vk_d[i] = issue_vk_in;
          qk_d[i] = issue_qk_in;
        end
`ifdef RS_AGE_ORDER_EN
        // Youngest rank among the rows still busy after this edge.
        age_d[i] = count_q[1:0] - (disp_fire ? 2'd1 : 2'd0);
`endif
      end
    end
    if (issue_fire && !disp_fire) begin
      count_d = count_q + 3'd1;
    end else if (!issue_fire && disp_fire) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        qj_q[i] <= '0;
        vk_q[i] <= '0;
        qk_q[i] <= '0;
`ifdef RS_AGE_ORDER_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      op_q    <= op_d;
      vj_q    <= vj_d;
      qj_q    <= qj_d;
      vk_q    <= vk_d;
      qk_q    <= qk_d;
`ifdef RS_AGE_ORDER_EN
      age_q   <= age_d;
`endif
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station (ENTRIES=3, RS_ID=1, DATA_W=32).
// Expected dispatches are queued when stimulus is driven; a monitor pops and compares on each handshake.
// Direct checks cover reset, ready/tag/count, stability under backpressure and reset mid-operation.
module tb_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        issue_valid_in;
  logic        issue_ready_out;
  logic [3:0]  issue_op_in;
  logic [31:0] issue_vj_in;
  logic [3:0]  issue_qj_in;
  logic [31:0] issue_vk_in;
  logic [3:0]  issue_qk_in;
  logic [3:0]  issue_tag_out;
  logic        dispatch_valid_out;
  logic        dispatch_ready_in;
  logic [3:0]  dispatch_op_out;
  logic [31:0] dispatch_vj_out;
  logic [31:0] dispatch_vk_out;
  logic [3:0]  dispatch_tag_out;
  logic        cdb_valid_in;
  logic [3:0]  cdb_tag_in;
  logic [31:0] cdb_data_in;
  logic [2:0]  count_out;

  reservation_station #(.ENTRIES(3), .RS_ID(1), .DATA_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
    .issue_op_in(issue_op_in), .issue_vj_in(issue_vj_in), .issue_qj_in(issue_qj_in),
    .issue_vk_in(issue_vk_in), .issue_qk_in(issue_qk_in), .issue_tag_out(issue_tag_out),
    .dispatch_valid_out(dispatch_valid_out), .dispatch_ready_in(dispatch_ready_in),
    .dispatch_op_out(dispatch_op_out), .dispatch_vj_out(dispatch_vj_out),
    .dispatch_vk_out(dispatch_vk_out), .dispatch_tag_out(dispatch_tag_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] vj,
                              input logic [31:0] vk, input logic [3:0] tag);
    exp_t e;
    e.op = op; e.vj = vj; e.vk = vk; e.tag = tag;
    return e;
  endfunction

  // Scoreboard monitor: every accepted dispatch must match the head of the queue.
  always @(negedge clk_in) begin
    if (!rst_in && dispatch_valid_out && dispatch_ready_in) begin
      if (sb.size() == 0) begin
        chk("unexpected_dispatch", {60'd0, dispatch_tag_out}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("disp_op",  {60'd0, dispatch_op_out},  {60'd0, mon_e.op});
        chk("disp_vj",  {32'd0, dispatch_vj_out},  {32'd0, mon_e.vj});
        chk("disp_vk",  {32'd0, dispatch_vk_out},  {32'd0, mon_e.vk});
        chk("disp_tag", {60'd0, dispatch_tag_out}, {60'd0, mon_e.tag});
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_in);
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj,
                           input logic [31:0] vk, input logic [3:0] qk);
    issue_valid_in = 1'b1;
    issue_op_in = op; issue_vj_in = vj; issue_qj_in = qj; issue_vk_in = vk; issue_qk_in = qk;
  endtask

  task automatic clr_issue();
    issue_valid_in = 1'b0;
    issue_op_in = '0; issue_vj_in = '0; issue_qj_in = '0; issue_vk_in = '0; issue_qk_in = '0;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid_in = 1'b1; cdb_tag_in = tag; cdb_data_in = data;
  endtask

  task automatic clr_cdb();
    cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_data_in = '0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    dispatch_ready_in = 1'b0;
    clr_issue();
    clr_cdb();
    step(); step();
    rst_in = 1'b0;

    // Reset state
    neg();
    chk("rst_issue_ready", 64'(issue_ready_out), 64'd1);
    chk("rst_disp_valid", 64'(dispatch_valid_out), 64'd0);
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_issue_tag", 64'(issue_tag_out), 64'h4);
    step();

    // Both operands ready at issue
    dispatch_ready_in = 1'b1;
    set_issue(4'h0, 32'd5, 4'd0, 32'd7, 4'd0);
    sb.push_back(mk(4'h0, 32'd5, 32'd7, 4'b0100));
    neg();
    chk("t1_issue_tag", 64'(issue_tag_out), 64'h4);
    step(); clr_issue();
    neg();
    chk("t1_count1", 64'(count_out), 64'd1);
    chk("t1_disp_valid", 64'(dispatch_valid_out), 64'd1);
    step();
    neg();
    chk("t1_count0", 64'(count_out), 64'd0);
    chk("t1_disp_idle", 64'(dispatch_valid_out), 64'd0);
    step();

    // Operand j waits for CDB tag 1001
    set_issue(4'h1, 32'hDEAD, 4'b1001, 32'd3, 4'd0);
    sb.push_back(mk(4'h1, 32'd42, 32'd3, 4'b0100));
    step(); clr_issue();
    set_cdb(4'b1001, 32'd42);
    neg();
    chk("t2_not_ready", 64'(dispatch_valid_out), 64'd0);
    chk("t2_count", 64'(count_out), 64'd1);
    step(); clr_cdb();
    neg();
    chk("t2_disp_valid", 64'(dispatch_valid_out), 64'd1);
    step();
    drain("t2_drain");

    // Issue-cycle CDB bypass on operand k
    set_issue(4'h2, 32'd11, 4'd0, 32'hBEEF, 4'b1010);
    set_cdb(4'b1010, 32'd9);
    sb.push_back(mk(4'h2, 32'd11, 32'd9, 4'b0100));
    step(); clr_issue(); clr_cdb();
    neg();
    chk("t3_disp_valid", 64'(dispatch_valid_out), 64'd1);
    step();
    drain("t3_drain");

    // Fill with unresolved ops, resolve under backpressure, then release
    dispatch_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_issue(4'(3 + i), 32'hF00, 4'(9 + i), 32'(1 + i), 4'd0);
      sb.push_back(mk(4'(3 + i), 32'(10 * (i + 1)), 32'(1 + i), 4'(4 + i)));
      neg();
      chk("t4_issue_tag", 64'(issue_tag_out), 64'(4 + i));
      step();
    end
    clr_issue();
    neg();
    chk("t4_full_ready", 64'(issue_ready_out), 64'd0);
    chk("t4_full_count", 64'(count_out), 64'd3);
    chk("t4_none_valid", 64'(dispatch_valid_out), 64'd0);
    step();
    set_cdb(4'b1011, 32'd30);
    step();
    set_cdb(4'b1010, 32'd20);
    neg();
    chk("t4_row2_tag", 64'(dispatch_tag_out), 64'h6);
    chk("t4_row2_vj", 64'(dispatch_vj_out), 64'd30);
    step();
    set_cdb(4'b1001, 32'd10);
    neg();
    chk("t4_row1_tag", 64'(dispatch_tag_out), 64'h5);
    step(); clr_cdb();
    for (int i = 0; i < 2; i++) begin
      neg();
      chk("t4_hold_tag", 64'(dispatch_tag_out), 64'h4);
      chk("t4_hold_vj", 64'(dispatch_vj_out), 64'd10);
      chk("t4_hold_vk", 64'(dispatch_vk_out), 64'd1);
      step();
    end
    dispatch_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t4_burst_valid", 64'(dispatch_valid_out), 64'd1);
      step();
    end
    neg();
    chk("t4_count_empty", 64'(count_out), 64'd0);
    step();
    drain("t4_drain");

    // Full station: dispatch and issue in the same cycle
    dispatch_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_issue(4'(6 + i), 32'(100 + i), 4'd0, 32'd0, 4'd0);
      sb.push_back(mk(4'(6 + i), 32'(100 + i), 32'd0, 4'(4 + i)));
      step();
    end
    set_issue(4'h9, 32'd200, 4'd0, 32'd0, 4'd0);
    dispatch_ready_in = 1'b1;
    neg();
    chk("t5_full_not_ready", 64'(issue_ready_out), 64'd0);
    step();
    dispatch_ready_in = 1'b0;
`ifdef RS_AGE_ORDER_EN
    sb.push_back(mk(4'h9, 32'd200, 32'd0, 4'b0100));
`else
    sb.push_front(mk(4'h9, 32'd200, 32'd0, 4'b0100));
`endif
    neg();
    chk("t5_freed_ready", 64'(issue_ready_out), 64'd1);
    chk("t5_freed_tag", 64'(issue_tag_out), 64'h4);
    chk("t5_count_dec", 64'(count_out), 64'd2);
    step(); clr_issue();
    neg();
    chk("t5_count_refill", 64'(count_out), 64'd3);
    step();
    dispatch_ready_in = 1'b1;
    drain("t5_drain");

    // Dispatch order between an older row 2 and a younger row 0
    set_issue(4'hA, 32'h0, 4'b1001, 32'hA0, 4'd0);
    sb.push_back(mk(4'hA, 32'd50, 32'hA0, 4'b0100));
    step();
    set_issue(4'hC, 32'h0, 4'b1010, 32'hC0, 4'd0);
    step();
    set_issue(4'hE, 32'h0, 4'b1011, 32'hE0, 4'd0);
    step(); clr_issue();
    set_cdb(4'b1001, 32'd50);
    step(); clr_cdb();
    step();
    set_issue(4'hB, 32'h0, 4'b1011, 32'hB0, 4'd0);
    neg();
    chk("t6_b_tag", 64'(issue_tag_out), 64'h4);
`ifdef RS_AGE_ORDER_EN
    sb.push_back(mk(4'hE, 32'd77, 32'hE0, 4'b0110));
    sb.push_back(mk(4'hB, 32'd77, 32'hB0, 4'b0100));
`else
    sb.push_back(mk(4'hB, 32'd77, 32'hB0, 4'b0100));
    sb.push_back(mk(4'hE, 32'd77, 32'hE0, 4'b0110));
`endif
    step(); clr_issue();
    set_cdb(4'b1011, 32'd77);
    step(); clr_cdb();
    step(); step();
    set_cdb(4'b1010, 32'd60);
    sb.push_back(mk(4'hC, 32'd60, 32'hC0, 4'b0101));
    step(); clr_cdb();
    drain("t6_drain");

    // Reset mid-operation discards a ready row and blocks dispatch in the reset cycle
    dispatch_ready_in = 1'b0;
    set_issue(4'hD, 32'd1, 4'd0, 32'd2, 4'd0);
    step(); clr_issue();
    neg();
    chk("t7_pre_valid", 64'(dispatch_valid_out), 64'd1);
    step();
    rst_in = 1'b1;
    dispatch_ready_in = 1'b1;
    neg();
    chk("t7_rst_no_disp", 64'(dispatch_valid_out), 64'd0);
    step();
    rst_in = 1'b0;
    dispatch_ready_in = 1'b0;
    neg();
    chk("t7_post_count", 64'(count_out), 64'd0);
    chk("t7_post_valid", 64'(dispatch_valid_out), 64'd0);
    chk("t7_post_ready", 64'(issue_ready_out), 64'd1);
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
